// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the instruction fetch front end.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN,
    DROP,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    word_t inst;
    word_t pc;
  } fetch_entry_t;

  localparam word_t PC_STEP = 32'd4;

  // Redirect targets are word aligned; low two bits are discarded.
  function automatic word_t align_pc(word_t a);
    return {a[31:2], 2'b00};
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic word_t sat_inc(word_t v, logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch stage bus: instruction memory handshake, redirect/halt control and decode handshake.
interface fetch_if;
  import cpu_types_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  word_t imemload;
  logic  ihit;
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  logic  deq_ready;
  logic  inst_valid;
  word_t inst;
  word_t pc_out;
  word_t npc_out;
  logic  halted;

  modport fs (
    output imemREN, imemaddr, inst_valid, inst, pc_out, npc_out, halted,
    input  imemload, ihit, redirect, redirect_pc, halt, deq_ready
  );

  modport tb (
    input  imemREN, imemaddr, inst_valid, inst, pc_out, npc_out, halted,
    output imemload, ihit, redirect, redirect_pc, halt, deq_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO of fetched {inst, pc} entries. Flush beats enq and deq.
module fetch_queue
  import cpu_types_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       i_enq,
  input  fetch_entry_t               i_enq_data,
  input  logic                       i_deq,
  input  logic                       i_flush,
  output logic [$clog2(QDEPTH):0]    o_count,
  output logic                       o_head_valid,
  output fetch_entry_t               o_head
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(QDEPTH);

  fetch_entry_t   r_mem [QDEPTH];
  logic [AW-1:0]  r_rd_ptr;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW:0]    r_count;

  logic w_do_enq;
  logic w_do_deq;

  assign w_do_deq = i_deq && (r_count != '0);
  // A full queue may still accept a write when the head leaves in the same cycle.
  assign w_do_enq = i_enq && ((r_count != FULL) || w_do_deq);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_enq && !w_do_deq)      r_count <= r_count + 1'b1;
      else if (!w_do_enq && w_do_deq) r_count <= r_count - 1'b1;
    end
  end

  // Storage needs no reset; empty slots are never presented.
  always_ff @(posedge CLK) begin
    if (w_do_enq && !i_flush) r_mem[r_wr_ptr] <= i_enq_data;
  end

  assign o_count      = r_count;
  assign o_head_valid = (r_count != '0);
  assign o_head       = o_head_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, issues REN/ihit reads, queues words for decode,
// handles redirects (including abandoning an in-flight miss) and a sticky halt.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t       PC_INIT = 32'h0000_0000,
  parameter int unsigned QDEPTH  = 2
) (
  input  logic  CLK,
  input  logic  RST,
  fetch_if.fs   bus
`ifdef FETCH_PERF_EN
  ,
  output word_t fetch_count,
  output word_t squash_count,
  output word_t stall_cycles
`endif
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  fetch_state_t  r_state;
  fetch_state_t  w_state_next;
  word_t         r_fetch_pc;
  word_t         w_fetch_pc_next;
  word_t         r_req_pc;
  word_t         w_req_pc_next;
  logic          r_halt_pend;
  logic          w_halt_pend_next;

  logic          w_ren;
  word_t         w_addr;
  logic          w_enq;
  logic          w_deq;
  logic          w_flush;
  logic [CW-1:0] w_count;
  logic          w_head_valid;
  fetch_entry_t  w_head;
  fetch_entry_t  w_enq_data;

  assign w_enq_data.inst = bus.imemload;
  assign w_enq_data.pc   = r_fetch_pc;
  assign w_deq           = w_head_valid && bus.deq_ready;

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .CLK          (CLK),
    .RST          (RST),
    .i_enq        (w_enq),
    .i_enq_data   (w_enq_data),
    .i_deq        (w_deq),
    .i_flush      (w_flush),
    .o_count      (w_count),
    .o_head_valid (w_head_valid),
    .o_head       (w_head)
  );

  // Control state, fetch PC, held miss address and pending-halt flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= RUN;
      r_fetch_pc  <= PC_INIT;
      r_req_pc    <= PC_INIT;
      r_halt_pend <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_fetch_pc  <= w_fetch_pc_next;
      r_req_pc    <= w_req_pc_next;
      r_halt_pend <= w_halt_pend_next;
    end
  end

  // Next-state, request and queue control decode.
  always_comb begin
    w_ren            = 1'b0;
    w_addr           = r_fetch_pc;
    w_state_next     = r_state;
    w_fetch_pc_next  = r_fetch_pc;
    w_req_pc_next    = r_req_pc;
    w_halt_pend_next = r_halt_pend;
    w_enq            = 1'b0;
    w_flush          = 1'b0;
    case (r_state)
      RUN: begin
        // Registered count gates REN, so a full queue never has a request in flight.
        w_ren = (w_count < QFULL);
        if (bus.redirect) begin
          w_flush         = 1'b1;
          w_fetch_pc_next = align_pc(bus.redirect_pc);
        end else if (w_ren && bus.ihit) begin
          w_enq           = 1'b1;
          w_fetch_pc_next = r_fetch_pc + PC_STEP;
        end
        // An outstanding miss cannot be cancelled at the memory; park in DROP to absorb it.
        if ((bus.redirect || bus.halt) && w_ren && !bus.ihit) begin
          w_state_next     = DROP;
          w_req_pc_next    = r_fetch_pc;
          w_halt_pend_next = bus.halt;
        end else if (bus.halt) begin
          w_state_next = HALTED;
        end
      end
      DROP: begin
        w_ren  = 1'b1;
        w_addr = r_req_pc;
        if (bus.redirect) w_fetch_pc_next = align_pc(bus.redirect_pc);
        if (bus.ihit) begin
          w_state_next     = (r_halt_pend || bus.halt) ? HALTED : RUN;
          w_halt_pend_next = 1'b0;
        end else begin
          w_halt_pend_next = r_halt_pend || bus.halt;
        end
      end
      HALTED: begin
        w_ren = 1'b0;
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  assign bus.imemREN    = w_ren;
  assign bus.imemaddr   = w_addr;
  assign bus.inst_valid = w_head_valid;
  assign bus.inst       = w_head.inst;
  assign bus.pc_out     = w_head.pc;
  assign bus.npc_out    = w_head_valid ? w_head.pc + PC_STEP : '0;
  assign bus.halted     = (r_state == HALTED);

`ifdef FETCH_PERF_EN
  logic  w_squash;
  logic  w_stall;
  word_t r_fetch_count;
  word_t r_squash_count;
  word_t r_stall_cycles;

  // A returned word is squashed when it lands with a RUN redirect or while draining in DROP.
  assign w_squash = bus.ihit && (((r_state == RUN) && w_ren && bus.redirect) ||
                                 (r_state == DROP));
  assign w_stall  = w_ren && !bus.ihit;

  // Saturating event counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fetch_count  <= '0;
      r_squash_count <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_fetch_count  <= sat_inc(r_fetch_count, w_enq);
      r_squash_count <= sat_inc(r_squash_count, w_squash);
      r_stall_cycles <= sat_inc(r_stall_cycles, w_stall);
    end
  end

  assign fetch_count  = r_fetch_count;
  assign squash_count = r_squash_count;
  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic, checked
// against a transaction-level model of the fetch stream held in a scoreboard queue.
module tb_fetch_stage;
  import cpu_types_pkg::*;

  localparam word_t PC_INIT = 32'h0000_0000;
  localparam int    QD      = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  fetch_if u_if ();

`ifdef FETCH_PERF_EN
  word_t fc_o, sq_o, st_o;
`endif

  fetch_stage #(
    .PC_INIT (PC_INIT),
    .QDEPTH  (QD)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (u_if.fs)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count  (fc_o),
    .squash_count (sq_o),
    .stall_cycles (st_o)
`endif
  );

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;

  // Reference model: expected decode-visible entries and where fetching stands.
  typedef enum {M_RUN, M_DROP, M_HALT} mmode_e;
  fetch_entry_t m_q[$];
  word_t  m_pc, m_hold;
  logic   m_pend;
  mmode_e m_mode;
  word_t  m_fc, m_sq, m_st;

  // Inputs driven during the current cycle.
  logic  d_hit, d_rd, d_hl, d_dq;
  word_t d_rpc;

  function automatic word_t mem_word(word_t a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F1E;
  endfunction

  function automatic logic m_ren();
    return ((m_mode == M_RUN) && (m_q.size() < QD)) || (m_mode == M_DROP);
  endfunction

  function automatic word_t m_addr();
    return (m_mode == M_DROP) ? m_hold : m_pc;
  endfunction

  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc   = PC_INIT;
    m_hold = PC_INIT;
    m_pend = 1'b0;
    m_mode = M_RUN;
    m_fc   = '0;
    m_sq   = '0;
    m_st   = '0;
  endtask

  // Apply one clock edge worth of fetch-stream rules.
  task automatic model_edge();
    logic ren, hit;
    word_t addr;
    fetch_entry_t e;
    ren  = m_ren();
    addr = m_addr();
    hit  = ren && d_hit;
    if (ren && !d_hit) m_st++;
    case (m_mode)
      M_RUN: begin
        if (d_rd) begin
          m_q.delete();
          m_pc = d_rpc & ~32'h3;
          if (hit) m_sq++;
        end else begin
          if (d_dq && (m_q.size() > 0)) void'(m_q.pop_front());
          if (hit) begin
            e.inst = mem_word(addr);
            e.pc   = addr;
            m_q.push_back(e);
            m_pc = addr + 32'd4;
            m_fc++;
          end
        end
        if ((d_rd || d_hl) && ren && !hit) begin
          m_mode = M_DROP;
          m_hold = addr;
          m_pend = d_hl;
        end else if (d_hl) begin
          m_mode = M_HALT;
        end
      end
      M_DROP: begin
        if (d_dq && (m_q.size() > 0)) void'(m_q.pop_front());
        if (d_rd) m_pc = d_rpc & ~32'h3;
        if (d_hl) m_pend = 1'b1;
        if (hit) begin
          m_sq++;
          m_mode = m_pend ? M_HALT : M_RUN;
          m_pend = 1'b0;
        end
      end
      default: begin
        if (d_dq && (m_q.size() > 0)) void'(m_q.pop_front());
      end
    endcase
  endtask

  // Monitor: compare presented outputs with the scoreboard head, away from the active edge.
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("imemREN", 32'(u_if.imemREN), 32'(m_ren()));
      if (m_ren()) chk("imemaddr", u_if.imemaddr, m_addr());
      chk("halted", 32'(u_if.halted), 32'(m_mode == M_HALT));
      chk("inst_valid", 32'(u_if.inst_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        chk("inst", u_if.inst, m_q[0].inst);
        chk("pc_out", u_if.pc_out, m_q[0].pc);
        chk("npc_out", u_if.npc_out, m_q[0].pc + 32'd4);
      end else begin
        chk("inst_empty", u_if.inst, 32'h0);
        chk("pc_out_empty", u_if.pc_out, 32'h0);
        chk("npc_out_empty", u_if.npc_out, 32'h0);
      end
`ifdef FETCH_PERF_EN
      chk("fetch_count", fc_o, m_fc);
      chk("squash_count", sq_o, m_sq);
      chk("stall_cycles", st_o, m_st);
`endif
    end
  end

  // Drive one cycle of inputs (called just after a rising edge), then advance the model.
  task automatic step(input logic hit, input logic rd, input word_t rpc, input logic hl,
                      input logic dq);
    d_hit = hit && u_if.imemREN;
    d_rd  = rd;
    d_rpc = rpc;
    d_hl  = hl;
    d_dq  = dq;
    u_if.ihit        = d_hit;
    u_if.imemload    = d_hit ? mem_word(u_if.imemaddr) : $urandom();
    u_if.redirect    = rd;
    u_if.redirect_pc = rpc;
    u_if.halt        = hl;
    u_if.deq_ready   = dq;
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    u_if.ihit        = 1'b0;
    u_if.imemload    = '0;
    u_if.redirect    = 1'b0;
    u_if.redirect_pc = '0;
    u_if.halt        = 1'b0;
    u_if.deq_ready   = 1'b0;
    RST = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    model_reset();
    mon_en = 1'b1;
    do_reset();

    // Zero-wait streaming: one instruction per cycle.
    repeat (6) step(1'b1, 1'b0, '0, 1'b0, 1'b1);

    // Backpressure fills the queue, REN drops, then drains and resumes at 8.
    do_reset();
    repeat (4) step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0, '0, 1'b0, 1'b1);

    // Miss at 0x10 abandoned by a redirect to 0x200.
    do_reset();
    repeat (4) step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h200, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    repeat (4) step(1'b1, 1'b0, '0, 1'b0, 1'b1);

    // Redirect to misaligned 0x103 coinciding with the hit at 0x20.
    do_reset();
    repeat (8) step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h103, 1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b0, '0, 1'b0, 1'b1);

    // Halt during an outstanding miss; queued entries still drain, redirect ignored.
    do_reset();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h300, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0, '0, 1'b0, 1'b1);

    // PC wrap at the top of the address space.
    do_reset();
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b0, '0, 1'b0, 1'b1);

    // Randomized traffic; each block starts with an asynchronous reset, often mid-request.
    for (int b = 0; b < 12; b++) begin
      do_reset();
      for (int c = 0; c < 250; c++) begin
        step(($urandom % 4) != 0, ($urandom % 16) == 0, $urandom,
             ($urandom % 400) == 0, ($urandom % 3) != 0);
      end
    end

    @(negedge CLK);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch front end directly upstream of decode and the immediate generator.
- Owns the PC, issues instruction-memory reads with the REN/ihit handshake, and buffers fetched words in a small queue.
- Presents {inst, pc, npc} to decode with a valid/ready handshake.
- Handles redirects (branch/jump), including abandoning an in-flight miss, and halts.

Parameters:
- PC_INIT, 32'h0000_0000: PC loaded on reset.
- QDEPTH, 2: instruction queue entries (power of 2, ≥2).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- imemREN  output  1  instruction read request.
- imemaddr  output  32 (word_t)  request address; stable while imemREN high and ihit low.
- imemload  input  32 (word_t)  returned instruction; valid when ihit.
- ihit  input  1  request complete this cycle.
- redirect  input  1  one-cycle pulse: squash and refetch from redirect_pc.
- redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 0).
- halt  input  1  stop fetching; sticky until RST.
- deq_ready  input  1  decode accepts head entry this cycle.
- inst_valid  output  1  queue head valid.
- inst  output  32  head instruction; feeds imm generator inst.
- pc_out  output  32  head PC.
- npc_out  output  32  head PC + 4, modulo 2^32.
- halted  output  1  state is HALTED.

Behaviour:
- Interface: one clock, CLK. Reset is asynchronous and active-high on RST.
- Reset state:
  - fetch_pc = PC_INIT; queue empty; state RUN; counters 0.
  - Outputs: inst_valid=0, inst=0, pc_out=0, npc_out=0, halted=0.
  - imemREN=1 and imemaddr=PC_INIT from the first cycle after reset is released.
- States:
  - RUN: imemREN = (count < QDEPTH); imemaddr = fetch_pc.
  - DROP: imemREN=1; imemaddr = req_pc, which is held. Completes an abandoned request.
  - HALTED: imemREN=0.
- Fetch on ihit in RUN with no redirect:
  - Enqueue {imemload, fetch_pc}.
  - fetch_pc += 4, wrapping at 2^32.
  - Zero-wait ihit gives one instruction per cycle.
- Dequeue: on inst_valid && deq_ready, the head pops. Head outputs are combinational from the queue and are zero when empty.
- Occupancy:
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - When full, no request issues, because REN uses the registered count.
  - Minimum latency is ihit cycle → inst_valid next cycle.
- Redirect (priority over enqueue):
  - Queue is cleared at the edge; dequeue in that cycle is ignored.
  - fetch_pc = redirect_pc.
  - If imemREN=1 and ihit=0 in that cycle: req_pc ← current address, go to DROP.
  - Else stay in RUN; a same-cycle ihit word is discarded.
- DROP:
  - On ihit, discard the word and return to RUN (or HALTED if halt was latched).
  - A redirect while in DROP only overwrites fetch_pc.
- halt, sticky:
  - In RUN with an outstanding request (REN=1, ihit=0): latch halt_pend, move to DROP, finish the request, discard it, go to HALTED.
  - Otherwise go to HALTED next edge.
  - The queue keeps draining while halted.
  - redirect is ignored in HALTED.
- RST mid-request: immediate return to reset state. Memory must tolerate REN dropping.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds outputs fetch_count (32), squash_count (32), and stall_cycles (32).
  - fetch_count: enqueued words.
  - squash_count: words discarded by redirect or DROP.
  - stall_cycles: cycles with REN=1 and ihit=0.
  - All saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- cpu_types_pkg:
  - fetch_state_t enum {RUN, DROP, HALTED}.
  - fetch_entry_t struct {word_t inst; word_t pc}.
  - Constant PC_STEP = 4.
- fetch_if interface: modports fs (stage) and tb.
- Sub-module fetch_queue: parameterized QDEPTH FIFO of fetch_entry_t with enq, deq, flush, count, and head. Flush has priority over enq and deq.

Test Plan:
- Reset with PC_INIT=0, ihit tied 1, deq_ready=1 → imemaddr sequence 0,4,8,C; inst/pc_out follow one cycle later; npc_out = pc_out+4.
- deq_ready=0, ihit=1 → after 2 enqueues imemREN=0, queue holds PCs 0 and 4. Raise deq_ready → pops 0 then 4; fetching resumes at 8.
- Miss at addr 0x10 (ihit low 3 cycles), then redirect to 0x200 → imemaddr held 0x10 through ihit, word discarded, next request 0x200, first inst_valid has pc_out=0x200.
- Redirect to 0x103 coinciding with ihit at 0x20 → 0x20 word not enqueued, queue empty next cycle, next imemaddr 0x100.
- halt during outstanding miss → REN held until ihit, word dropped, halted=1, REN=0, queued entries still dequeue; later redirect ignored.
- With FETCH_PERF_EN: 5 fetched, 1 redirect with 1 dropped, 3 miss cycles → fetch_count=5, squash_count=1, stall_cycles=3; RST clears all.
